// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-port register file with busy scoreboard (ID stage)
//
// Purpose:
//   2**ADDR_W x DATA_W register array with NRD combinational read ports and
//   two prioritised synchronous write ports (port 0 = WB, port 1 = late
//   load/MDU return; port 1 wins on an address clash). Optional same-cycle
//   write-to-read bypass. A per-register busy bit is set when an instruction
//   with a destination issues (mark) and cleared when that register is
//   written, so the hazard unit can stall on pending producers.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (array and busy bits cleared)
//   raddr      NRD read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata      NRD read data,      port k at [k*DATA_W +: DATA_W]
//   rbusy      busy flag of the register addressed by read port k
//   we         write enables, we[0] = WB port, we[1] = late-return port
//   waddr      write addresses, port j at [j*ADDR_W +: ADDR_W]
//   wdata      write data,      port j at [j*DATA_W +: DATA_W]
//   mark_en    set busy bit of mark_addr at the next edge
//   mark_addr  destination being marked
//   busy_any   OR of all registered busy bits
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD*ADDR_W-1:0]    raddr,
    output logic [NRD*DATA_W-1:0]    rdata,
    output logic [NRD-1:0]           rbusy,
    input  logic [1:0]               we,
    input  logic [2*ADDR_W-1:0]      waddr,
    input  logic [2*DATA_W-1:0]      wdata,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    output logic                     busy_any
);

    localparam int DEPTH    = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [ADDR_W-1:0] waddr_w [2];
    logic [DATA_W-1:0] wdata_w [2];
    logic [1:0]        wr_ok;
    logic              wr0_keep;

    // Unpack write ports; a write to r0 never reaches the array when it is
    // hardwired to zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wport
            assign waddr_w[gi] = waddr[gi*ADDR_W +: ADDR_W];
            assign wdata_w[gi] = wdata[gi*DATA_W +: DATA_W];
            assign wr_ok[gi]   = we[gi] && !(HAS_ZERO && (waddr_w[gi] == '0));
        end
    endgenerate

    // Port 0 is dropped when port 1 targets the same register.
    assign wr0_keep = wr_ok[0] && !(wr_ok[1] && (waddr_w[1] == waddr_w[0]));

    // Scoreboard next state: writes clear, then a mark sets, so a mark and a
    // write to the same register in one cycle leave it busy (new producer).
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < 2; j++) begin
            if (we[j]) begin
                busy_d[waddr_w[j]] = 1'b0;
            end
        end
        if (mark_en) begin
            busy_d[mark_addr] = 1'b1;
        end
        if (HAS_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr0_keep) begin
                mem_q[waddr_w[0]] <= wdata_w[0];
            end
            if (wr_ok[1]) begin
                mem_q[waddr_w[1]] <= wdata_w[1];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports. Bypass data is suppressed during reset so the array
    // contents are visible; the busy mask follows the write enables only.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
            logic [ADDR_W-1:0] ra;
            logic              hit0;
            logic              hit1;
            logic              is_zero;
            logic [DATA_W-1:0] rd;
            logic              rb;

            assign ra      = raddr[gi*ADDR_W +: ADDR_W];
            assign hit0    = we[0] && (waddr_w[0] == ra);
            assign hit1    = we[1] && (waddr_w[1] == ra);
            assign is_zero = HAS_ZERO && (ra == '0);

            always_comb begin
                rd = mem_q[ra];
                rb = busy_q[ra];
                if (is_zero) begin
                    rd = '0;
                    rb = 1'b0;
                end else if (HAS_BYP) begin
                    if (!rst) begin
                        if (hit1) begin
                            rd = wdata_w[1];
                        end else if (hit0) begin
                            rd = wdata_w[0];
                        end
                    end
                    // The value being forwarded is the one the reader waits on.
                    if (hit0 || hit1) begin
                        rb = 1'b0;
                    end
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd;
            assign rbusy[gi]                  = rb;
        end
    endgenerate

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- directed + randomized bench for regfile_mp.
// Two instances share all inputs: dut_a (BYPASS=1) and dut_b (BYPASS=0).
// Expected values come from a plain array/bit model updated once per edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic        busy_any_a, busy_any_b;

    int n_chk  = 0;
    int n_fail = 0;
    int n_txn  = 0;

    logic [31:0] mdl_mem  [32];
    bit          mdl_busy [32];

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .we(we), .waddr(waddr), .wdata(wdata), .mark_en(mark_en),
        .mark_addr(mark_addr), .busy_any(busy_any_a)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .mark_en(mark_en),
        .mark_addr(mark_addr), .busy_any(busy_any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input logic [1:0] w,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input bit me, input logic [4:0] ma,
                         input logic [4:0] r0, input logic [4:0] r1);
        rst       = r;
        we        = w;
        waddr     = {a1, a0};
        wdata     = {d1, d0};
        mark_en   = me;
        mark_addr = ma;
        raddr     = {r1, r0};
    endtask

    // Does write port j hit address a this cycle?
    function automatic bit wr_hit(input int j, input logic [4:0] a);
        return we[j] && (waddr[j*5 +: 5] == a);
    endfunction

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp && !rst) begin
            if (wr_hit(1, a)) return wdata[63:32];
            if (wr_hit(0, a)) return wdata[31:0];
        end
        return mdl_mem[a];
    endfunction

    function automatic logic exp_rb(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (byp && (wr_hit(0, a) || wr_hit(1, a))) return 1'b0;
        return mdl_busy[a];
    endfunction

    function automatic logic mdl_any();
        for (int i = 0; i < 32; i++) if (mdl_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Mid-cycle: compare every output of both instances with the model.
    task automatic sample_all();
        logic [4:0] ra;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ra = raddr[k*5 +: 5];
            chk($sformatf("rdata_a%0d r%0d", k, ra), rdata_a[k*32 +: 32], exp_rd(1'b1, ra));
            chk($sformatf("rdata_b%0d r%0d", k, ra), rdata_b[k*32 +: 32], exp_rd(1'b0, ra));
            chk($sformatf("rbusy_a%0d r%0d", k, ra), rbusy_a[k], exp_rb(1'b1, ra));
            chk($sformatf("rbusy_b%0d r%0d", k, ra), rbusy_b[k], exp_rb(1'b0, ra));
        end
        chk("busy_any_a", busy_any_a, mdl_any());
        chk("busy_any_b", busy_any_b, mdl_any());
    endtask

    // Apply this cycle's edge to the model, log the transaction, take the edge.
    task automatic advance();
        logic [4:0] a;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mdl_mem[i]  = 32'd0;
                mdl_busy[i] = 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                a = waddr[j*5 +: 5];
                if (we[j] && a != 5'd0) mdl_mem[a] = wdata[j*32 +: 32];
            end
            for (int j = 0; j < 2; j++) begin
                a = waddr[j*5 +: 5];
                if (we[j]) mdl_busy[a] = 1'b0;
            end
            if (mark_en && mark_addr != 5'd0) mdl_busy[mark_addr] = 1'b1;
        end
        $display("txn %0d rst=%b we=%b wa=%0d/%0d wd=%h/%h mark=%b@%0d ra=%0d/%0d",
                 n_txn, rst, we, waddr[4:0], waddr[9:5], wdata[31:0], wdata[63:32],
                 mark_en, mark_addr, raddr[4:0], raddr[9:5]);
        n_txn++;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample_all();
        advance();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mdl_mem[i]  = 32'd0;
            mdl_busy[i] = 1'b0;
        end

        // Reset held 3 cycles while both ports write r5; first cycle unchecked
        // since the array is uninitialised before the first reset edge.
        drive(1, 2'b11, 5, 32'hAAAA_0001, 5, 32'hAAAA_0002, 1, 5, 5, 5);
        @(posedge clk);
        #1;
        advance();
        cyc();
        cyc();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        sample_all();
        chk("r5 after reset", rdata_a[31:0], 32'd0);
        advance();

        // Read every register on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            cyc();
        end

        // Write r7 with both read ports on r7.
        drive(0, 2'b01, 7, 32'hDEADBEEF, 0, 0, 0, 0, 7, 7);
        sample_all();
        chk("byp r7 p0", rdata_a[31:0], 32'hDEADBEEF);
        chk("byp r7 p1", rdata_a[63:32], 32'hDEADBEEF);
        chk("nobyp r7 old", rdata_b[31:0], 32'd0);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
        sample_all();
        chk("nobyp r7 next", rdata_b[63:32], 32'hDEADBEEF);
        advance();

        // Same-address conflict: port 1 wins.
        drive(0, 2'b11, 9, 32'h1111_1111, 9, 32'h2222_2222, 0, 0, 9, 9);
        sample_all();
        chk("conflict byp", rdata_a[31:0], 32'h2222_2222);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        sample_all();
        chk("conflict stored", rdata_b[31:0], 32'h2222_2222);
        advance();

        // Different addresses: both written.
        drive(0, 2'b11, 3, 32'h1, 4, 32'h2, 0, 0, 3, 4);
        cyc();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 4);
        sample_all();
        chk("dual r3", rdata_b[31:0], 32'h1);
        chk("dual r4", rdata_b[63:32], 32'h2);
        advance();

        // Zero register: write and mark r0.
        drive(0, 2'b01, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0);
        sample_all();
        chk("r0 byp", rdata_a[31:0], 32'd0);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        sample_all();
        chk("r0 stored", rdata_b[31:0], 32'd0);
        chk("r0 rbusy", rbusy_b[0], 1'b0);
        chk("r0 busy_any", busy_any_a, 1'b0);
        advance();

        // Scoreboard sequence on r12.
        drive(0, 2'b00, 0, 0, 0, 0, 1, 12, 12, 12);
        sample_all();
        chk("mark same cyc", rbusy_b[0], 1'b0);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 12);
        sample_all();
        chk("r12 busy", rbusy_a[0], 1'b1);
        chk("r12 busy_any", busy_any_a, 1'b1);
        advance();
        drive(0, 2'b01, 12, 32'h0000_C0DE, 0, 0, 0, 0, 12, 12);
        sample_all();
        chk("r12 byp clr", rbusy_a[1], 1'b0);
        chk("r12 nobyp busy", rbusy_b[1], 1'b1);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 12);
        sample_all();
        chk("r12 cleared", rbusy_b[0], 1'b0);
        chk("r12 any clr", busy_any_b, 1'b0);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 1, 12, 12, 12);
        cyc();
        drive(0, 2'b01, 12, 32'h0000_BEEF, 0, 0, 1, 12, 12, 12);
        cyc();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 12);
        sample_all();
        chk("set wins", rbusy_a[0], 1'b1);
        chk("set wins data", rdata_b[31:0], 32'h0000_BEEF);
        advance();

        // Reset mid-operation.
        drive(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 20);
        cyc();
        drive(0, 2'b00, 0, 0, 0, 0, 1, 20, 4, 20);
        cyc();
        drive(1, 2'b01, 4, 32'h5555_5555, 0, 0, 1, 4, 4, 20);
        sample_all();
        chk("pre-rst busy", busy_any_a, 1'b1);
        advance();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 20);
        sample_all();
        chk("post-rst any", busy_any_a, 1'b0);
        chk("post-rst r4", rdata_b[31:0], 32'd0);
        advance();

        // Randomized traffic with collision-prone addresses.
        for (int n = 0; n < 250; n++) begin
            logic [4:0] a0, a1, ma, r0, r1;
            a0 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            ma = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 1) == 0) ? a0 : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                  a0, $urandom, a1, $urandom, 1'($urandom_range(0, 1)), ma, r0, r1);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the single-write regfile; sits in the ID stage of the pipeline.
- Provides NRD combinational read ports and two prioritised synchronous write ports (WB stage plus late load/MDU return).
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: ID sets a bit on issue, a write clears it. Lets the hazard unit stall on pending producers.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
BYPASS, 1, 1 = reads return same-cycle write data; 0 = reads see array contents only

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
raddr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rdata  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rbusy  out  NRD  busy flag of the register addressed by read port k
we  in  2  write enables; we[0] = WB port, we[1] = late-return port
waddr  in  2*ADDR_W  write addresses, port j at [j*ADDR_W +: ADDR_W]
wdata  in  2*DATA_W  write data, port j at [j*DATA_W +: DATA_W]
mark_en  in  1  set busy bit of mark_addr (instruction issued with destination)
mark_addr  in  ADDR_W  destination being marked
busy_any  out  1  OR of all busy bits

Behaviour:
- Storage: 2**ADDR_W x DATA_W array, plus a 2**ADDR_W busy vector.
- Reset (rst=1 at rising edge):
  - All registers load 0 and all busy bits clear.
  - Writes and marks in that cycle are ignored.
  - While rst=1, bypass is suppressed, so rdata shows array contents only.
  - From the first cycle after reset: every rdata=0, rbusy=0, busy_any=0.
  - A reset mid-operation discards pending marks; busy bits do not survive.
- Write, registered, one-cycle latency:
  - At the edge, for each j with we[j]=1, array[waddr_j] <= wdata_j.
  - Both ports target the same address: port 1 wins, port 0's data is dropped.
  - Different addresses: both are written in the same edge.
  - ZERO_REG=1: writes to address 0 are ignored.
- Read, combinational, port k:
  - ZERO_REG=1 and raddr_k=0: rdata_k=0 regardless of bypass.
  - Else, BYPASS=1, rst=0 and a write is enabled to raddr_k this cycle: rdata_k = that wdata, with port 1 having priority.
  - Otherwise rdata_k = array[raddr_k].
  - All NRD ports are independent and may alias the same address.
- Scoreboard, updated at the edge:
  - Clear: busy[a] <= 0 when any we[j]=1 with waddr_j=a.
  - Set: busy[mark_addr] <= 1 when mark_en=1.
  - Set and clear on the same address in the same cycle: set wins (the newer producer owns the register).
  - ZERO_REG=1: mark of address 0 is ignored; busy[0] stays 0.
  - Writing a register that is not busy is legal: the data is written and busy stays 0.
- rbusy_k, combinational:
  - ZERO_REG=1 and raddr_k=0: rbusy_k=0.
  - BYPASS=1: rbusy_k = busy[raddr_k] AND NOT (a write to raddr_k is enabled this cycle). The forwarded value is the one being awaited.
  - BYPASS=0: rbusy_k = busy[raddr_k].
  - A same-cycle mark does not affect rbusy until the next cycle.
- busy_any: OR of registered busy bits only; no combinational dependence on inputs.
- Address widths are exact; no out-of-range case exists.
- No X propagation from unused data when we=0.

Test Plan:
- Reset then read all 32 regs on both ports -> every rdata=0, rbusy=0, busy_any=0. Repeat with rst held 3 cycles while we=2'b11 to reg 5 -> reg 5 still 0 after release.
- Write 32'hDEADBEEF to r7 via port 0 with raddr0=7, raddr1=7 in the same cycle:
  - BYPASS=1 -> both rdata=32'hDEADBEEF that cycle.
  - BYPASS=0 -> old value that cycle, 32'hDEADBEEF the next cycle.
- Same-cycle conflict, port0 r9=32'h1111_1111 and port1 r9=32'h2222_2222 -> bypass and stored value = 32'h2222_2222. Separately, port0 r3=32'h1 and port1 r4=32'h2 -> both stored.
- Zero register: write r0=32'hFFFF_FFFF and mark r0 -> rdata for r0 = 0, rbusy = 0, busy_any unchanged.
- Scoreboard sequence:
  - mark r12 -> rbusy=1 from the next cycle, busy_any=1.
  - Write r12 -> rbusy=0 in the same cycle (BYPASS=1), busy clear at the next edge, busy_any=0.
  - Simultaneous write r12 and mark r12 -> r12 stays busy and holds the new data.
- Reset mid-operation: mark r4 and r20, assert rst one cycle -> busy_any=0 and r4 reads 0. A write to r4 in the reset cycle is ignored.
